// File: rtl/lut_load_ctrl_if.sv
// Host / LUT-side signal bundle for lut_load_ctrl.
// master: host plus LUT instance; slave: the controller.
interface lut_load_ctrl_if #(
    parameter int unsigned IN_WIDTH  = 3,
    parameter int unsigned OUT_WIDTH = 4
);
    logic                 load_start;
    logic [OUT_WIDTH-1:0] entry_data;
    logic                 entry_valid;
    logic                 entry_ready;
    logic [IN_WIDTH-1:0]  entry_idx;
    logic [IN_WIDTH-1:0]  key;
    logic                 key_valid;
    logic                 key_ready;
    logic [OUT_WIDTH-1:0] result;
    logic                 result_valid;
    logic                 table_valid;
    logic                 load_err;
    logic                 lut_d;
    logic                 lut_cs_n;
    logic [IN_WIDTH-1:0]  lut_sel;
    logic [OUT_WIDTH-1:0] lut_out;

    modport master (
        output load_start, entry_data, entry_valid, key, key_valid, lut_out,
        input  entry_ready, entry_idx, key_ready, result, result_valid,
               table_valid, load_err, lut_d, lut_cs_n, lut_sel
    );

    modport slave (
        input  load_start, entry_data, entry_valid, key, key_valid, lut_out,
        output entry_ready, entry_idx, key_ready, result, result_valid,
               table_valid, load_err, lut_d, lut_cs_n, lut_sel
    );
endinterface

// File: rtl/lut_load_ctrl.sv
// Serial-load LUT sequencer: accepts table entries from a host, shifts them
// into the LUT (highest index first, MSB first) and gates lookups until the
// table is complete.
// Optional macro LOAD_TIMEOUT_EN: abort a load after TIMEOUT idle cycles in
// LOAD_WAIT and pulse load_err; when undefined load_err is constant 0.
module lut_load_ctrl #(
    parameter int unsigned IN_WIDTH  = 3,
    parameter int unsigned OUT_WIDTH = 4,
    parameter int unsigned TIMEOUT   = 16
) (
    input logic            clk,
    input logic            rst,
    lut_load_ctrl_if.slave bus
);
    localparam int unsigned ENTRIES = 2 ** IN_WIDTH;
    // One counter serves both the bit count in LOAD_SHIFT and the idle
    // count in LOAD_WAIT; the states never overlap.
    localparam int unsigned CNT_MAX = (TIMEOUT > OUT_WIDTH) ? TIMEOUT : OUT_WIDTH;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {
        EMPTY,
        LOAD_WAIT,
        LOAD_SHIFT,
        READY
    } state_t;

    state_t               state_q, state_d;
    logic [OUT_WIDTH-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IN_WIDTH-1:0]  entry_idx_q, entry_idx_d;
    logic [OUT_WIDTH-1:0] result_q, result_d;
    logic                 result_valid_q, result_valid_d;
    logic                 table_valid_q, table_valid_d;
    logic                 load_err_q, load_err_d;
    logic                 lut_d_q, lut_d_d;
    logic                 lut_cs_n_q, lut_cs_n_d;
    logic                 entry_fire;
    logic                 key_fire;

    assign bus.entry_ready  = (state_q == LOAD_WAIT);
    assign bus.key_ready    = (state_q == READY);
    assign bus.lut_sel      = bus.key;
    assign bus.entry_idx    = entry_idx_q;
    assign bus.result       = result_q;
    assign bus.result_valid = result_valid_q;
    assign bus.table_valid  = table_valid_q;
    assign bus.load_err     = load_err_q;
    assign bus.lut_d        = lut_d_q;
    assign bus.lut_cs_n     = lut_cs_n_q;

    assign entry_fire = bus.entry_valid && bus.entry_ready;
    assign key_fire   = bus.key_valid && bus.key_ready;

    // Next-state, load sequencing and lookup capture.
    always_comb begin
        state_d        = state_q;
        shift_d        = shift_q;
        cnt_d          = '0;
        entry_idx_d    = entry_idx_q;
        result_d       = result_q;
        result_valid_d = key_fire;
        table_valid_d  = table_valid_q;
        load_err_d     = 1'b0;
        lut_d_d        = 1'b0;
        lut_cs_n_d     = 1'b1;

        if (key_fire) begin
            result_d = bus.lut_out;
        end

        case (state_q)
            EMPTY, READY: begin
                if (bus.load_start) begin
                    state_d       = LOAD_WAIT;
                    entry_idx_d   = IN_WIDTH'(ENTRIES - 1);
                    table_valid_d = 1'b0;
                end
            end
            LOAD_WAIT: begin
                if (entry_fire) begin
                    state_d    = LOAD_SHIFT;
                    shift_d    = bus.entry_data;
                    lut_cs_n_d = 1'b0;
                    lut_d_d    = bus.entry_data[OUT_WIDTH-1];
                end
`ifdef LOAD_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d       = EMPTY;
                    load_err_d    = 1'b1;
                    table_valid_d = 1'b0;
                    entry_idx_d   = IN_WIDTH'(ENTRIES - 1);
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            LOAD_SHIFT: begin
                if (cnt_q == CNT_W'(OUT_WIDTH - 1)) begin
                    if (entry_idx_q == '0) begin
                        state_d       = READY;
                        table_valid_d = 1'b1;
                    end else begin
                        state_d     = LOAD_WAIT;
                        entry_idx_d = entry_idx_q - IN_WIDTH'(1);
                    end
                end else begin
                    cnt_d      = cnt_q + CNT_W'(1);
                    shift_d    = shift_q << 1;
                    lut_cs_n_d = 1'b0;
                    lut_d_d    = shift_d[OUT_WIDTH-1];
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= EMPTY;
            shift_q        <= '0;
            cnt_q          <= '0;
            entry_idx_q    <= IN_WIDTH'(ENTRIES - 1);
            result_q       <= '0;
            result_valid_q <= 1'b0;
            table_valid_q  <= 1'b0;
            load_err_q     <= 1'b0;
            lut_d_q        <= 1'b0;
            lut_cs_n_q     <= 1'b1;
        end else begin
            state_q        <= state_d;
            shift_q        <= shift_d;
            cnt_q          <= cnt_d;
            entry_idx_q    <= entry_idx_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            table_valid_q  <= table_valid_d;
            load_err_q     <= load_err_d;
            lut_d_q        <= lut_d_d;
            lut_cs_n_q     <= lut_cs_n_d;
        end
    end
endmodule

// File: tb/tb_lut_load_ctrl.sv
// Bench for lut_load_ctrl: behavioural serial LUT, result scoreboard.
// Stall test outcome depends on LOAD_TIMEOUT_EN.
module tb_lut_load_ctrl;
    localparam int unsigned IN_WIDTH  = 3;
    localparam int unsigned OUT_WIDTH = 4;
    localparam int unsigned ENTRIES   = 2 ** IN_WIDTH;
    localparam int unsigned TIMEOUT   = 16;
    localparam int unsigned TBITS     = ENTRIES * OUT_WIDTH;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    lut_load_ctrl_if #(.IN_WIDTH(IN_WIDTH), .OUT_WIDTH(OUT_WIDTH)) lif ();

    lut_load_ctrl #(
        .IN_WIDTH (IN_WIDTH),
        .OUT_WIDTH(OUT_WIDTH),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(lif)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int cs_low_cnt = 0;
    logic [OUT_WIDTH-1:0] tbl [ENTRIES];
    logic [OUT_WIDTH-1:0] sb [$];
    logic [TBITS-1:0]     lut_mem;
    logic [TBITS-1:0]     cs_bits = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Serial LUT model: shifts in lut_d on every clk while cs_n is low.
    always @(posedge clk) begin
        if (lif.lut_cs_n == 1'b0) lut_mem <= {lut_mem[TBITS-2:0], lif.lut_d};
    end
    assign lif.lut_out = lut_mem[lif.lut_sel*OUT_WIDTH +: OUT_WIDTH];

    // Mid-cycle monitor: shift activity and scoreboard comparison.
    always @(negedge clk) begin
        if (lif.lut_cs_n == 1'b0) begin
            cs_low_cnt++;
            cs_bits = {cs_bits[TBITS-2:0], lif.lut_d};
        end
        if (lif.result_valid === 1'b1) begin
            if (sb.size() == 0) chk("spurious_result_valid", 32'd1, 32'd0);
            else chk("result", 32'(lif.result), 32'(sb.pop_front()));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic lookup(input int k);
        lif.key       = IN_WIDTH'(k);
        lif.key_valid = 1'b1;
        chk("key_ready", 32'(lif.key_ready), 32'd1);
        sb.push_back(tbl[k]);
        tick();
        lif.key_valid = 1'b0;
    endtask

    // Full reload; optional idle gap in LOAD_WAIT before entry gap_idx.
    task automatic load_table(input int gap_idx, input int gap_len, input bit expect_abort);
        int first_acc;
        int base;
        int extra;
        bit ok;
        logic [TBITS-1:0] exp_bits;
        first_acc = -1;
        exp_bits  = '0;
        base      = cs_low_cnt;
        extra     = (gap_idx >= 0) ? gap_len : 0;
        cyc       = 0;
        lif.load_start  = 1'b1;
        lif.entry_valid = 1'b1;
        lif.entry_data  = tbl[ENTRIES-1];
        tick();
        lif.load_start = 1'b0;
        chk("table_valid_drop", 32'(lif.table_valid), 32'd0);
        for (int k = ENTRIES - 1; k >= 0; k--) begin
            lif.entry_data = tbl[k];
            exp_bits = {exp_bits[TBITS-OUT_WIDTH-1:0], tbl[k]};
            ok = 1'b0;
            for (int w = 0; w < 20; w++) begin
                if (lif.entry_ready === 1'b1) begin
                    ok = 1'b1;
                    break;
                end
                tick();
            end
            if (!ok) begin
                chk("entry_ready_wait", 32'd0, 32'd1);
                lif.entry_valid = 1'b0;
                return;
            end
            chk("entry_idx", 32'(lif.entry_idx), 32'(k));
            if (k == gap_idx) begin
                lif.entry_valid = 1'b0;
                for (int g = 0; g < gap_len; g++) begin
                    tick();
                    chk("gap_cs_n", 32'(lif.lut_cs_n), 32'd1);
                    if (g < gap_len - 1 || !expect_abort)
                        chk("gap_entry_ready", 32'(lif.entry_ready), 32'd1);
                end
                if (expect_abort) begin
                    chk("abort_load_err", 32'(lif.load_err), 32'd1);
                    chk("abort_table_valid", 32'(lif.table_valid), 32'd0);
                    chk("abort_entry_ready", 32'(lif.entry_ready), 32'd0);
                    tick();
                    chk("load_err_pulse", 32'(lif.load_err), 32'd0);
                    chk("abort_key_ready", 32'(lif.key_ready), 32'd0);
                    chk("abort_cs_n", 32'(lif.lut_cs_n), 32'd1);
                    return;
                end
                chk("gap_load_err", 32'(lif.load_err), 32'd0);
                lif.entry_valid = 1'b1;
            end
            if (k == ENTRIES - 1) first_acc = cyc;
            tick();
        end
        lif.entry_valid = 1'b0;
        ok = 1'b0;
        for (int w = 0; w < 20; w++) begin
            if (lif.table_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        chk("table_valid_seen", 32'(ok), 32'd1);
        chk("first_accept_cycle", 32'(first_acc), 32'd1);
        chk("table_valid_cycle", 32'(cyc), 32'(1 + ENTRIES * (OUT_WIDTH + 1) + extra));
        chk("cs_low_cycles", 32'(cs_low_cnt - base), 32'(TBITS));
        chk("shifted_bits", 32'(cs_bits), 32'(exp_bits));
        chk("done_key_ready", 32'(lif.key_ready), 32'd1);
        chk("done_entry_ready", 32'(lif.entry_ready), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < ENTRIES; i++) tbl[i] = OUT_WIDTH'(15 - i);
        rst             = 1'b1;
        lif.load_start  = 1'b0;
        lif.entry_valid = 1'b0;
        lif.entry_data  = '0;
        lif.key         = '0;
        lif.key_valid   = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        repeat (10) tick();
        chk("rst_table_valid", 32'(lif.table_valid), 32'd0);
        chk("rst_key_ready", 32'(lif.key_ready), 32'd0);
        chk("rst_cs_n", 32'(lif.lut_cs_n), 32'd1);
        chk("rst_entry_idx", 32'(lif.entry_idx), 32'd7);
        chk("rst_result", 32'(lif.result), 32'd0);
        chk("rst_result_valid", 32'(lif.result_valid), 32'd0);
        chk("rst_entry_ready", 32'(lif.entry_ready), 32'd0);
        chk("rst_load_err", 32'(lif.load_err), 32'd0);

        // Lookup while EMPTY must not be accepted.
        lif.key       = 3'd5;
        lif.key_valid = 1'b1;
        repeat (3) tick();
        chk("empty_key_ready", 32'(lif.key_ready), 32'd0);
        lif.key_valid = 1'b0;

        load_table(-1, 0, 1'b0);
        lookup(5);
        lookup(0);
        lookup(7);
        tick();
        chk("result_hold", 32'(lif.result), 32'h8);
        chk("result_valid_pulse", 32'(lif.result_valid), 32'd0);

        load_table(3, 3, 1'b0);
        for (int k = 0; k < ENTRIES; k++) lookup(k);
        tick();

        // Lookup and reload in the same READY cycle, then reset mid-shift.
        lif.key        = 3'd2;
        lif.key_valid  = 1'b1;
        lif.load_start = 1'b1;
        chk("both_key_ready", 32'(lif.key_ready), 32'd1);
        sb.push_back(tbl[2]);
        tick();
        lif.load_start = 1'b0;
        chk("reload_table_valid", 32'(lif.table_valid), 32'd0);
        chk("reload_key_ready", 32'(lif.key_ready), 32'd0);
        chk("reload_entry_ready", 32'(lif.entry_ready), 32'd1);
        lif.entry_valid = 1'b1;
        lif.entry_data  = tbl[7];
        tick();
        lif.entry_valid = 1'b0;
        tick();
        chk("mid_shift_cs_n", 32'(lif.lut_cs_n), 32'd0);
        rst = 1'b1;
        tick();
        chk("rst_mid_cs_n", 32'(lif.lut_cs_n), 32'd1);
        chk("rst_mid_table_valid", 32'(lif.table_valid), 32'd0);
        chk("rst_mid_key_ready", 32'(lif.key_ready), 32'd0);
        chk("rst_mid_entry_ready", 32'(lif.entry_ready), 32'd0);
        chk("rst_mid_entry_idx", 32'(lif.entry_idx), 32'd7);
        rst           = 1'b0;
        lif.key_valid = 1'b0;
        tick();
        chk("post_rst_cs_n", 32'(lif.lut_cs_n), 32'd1);

        // Long host stall before idx 3.
`ifdef LOAD_TIMEOUT_EN
        load_table(3, TIMEOUT, 1'b1);
        load_table(-1, 0, 1'b0);
`else
        load_table(3, TIMEOUT, 1'b0);
`endif
        for (int k = ENTRIES - 1; k >= 0; k--) lookup(k);
        repeat (3) tick();
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
